// File: rtl/alu_exec_wb.sv
// rtl/alu_exec_wb.sv - execute + writeback stage feeding results back into the register file
module alu_exec_wb #(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_OP,
    input  logic [RADDR_W-1:0] DEST_REG,
    output logic               RegWrite,
    output logic [RADDR_W-1:0] WriteReg,
    output logic [WIDTH-1:0]   WriteData,
    output logic               ZERO,
    output logic               OVERFLOW,
    output logic               ERR_ILLEGAL,
    output logic [CNT_W-1:0]   OP_COUNT
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // FSM strobes
    logic capture_en;
    logic exec_en;
    logic wb_en;

    // captured operation
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [3:0]         op_q;
    logic [RADDR_W-1:0] dest_q;
    logic               illegal_q;

    // combinational ALU results
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic             alu_illegal;

    // State register; reset may land in any state and abandons the operation in flight
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, then one cycle each for execute and writeback
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (IN_VALID) state_next = S_EXEC;
            S_EXEC:  state_next = S_WB;
            S_WB:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: handshake plus one-hot strobes for the datapath
    always_comb begin
        IN_READY   = 1'b0;
        capture_en = 1'b0;
        exec_en    = 1'b0;
        wb_en      = 1'b0;
        case (state)
            S_IDLE: begin
                IN_READY   = 1'b1;
                capture_en = IN_VALID;
            end
            S_EXEC:  exec_en = 1'b1;
            S_WB:    wb_en   = 1'b1;
            default: IN_READY = 1'b0;
        endcase
    end

    // ALU: SLT uses the subtract sign corrected by overflow, so it stays right when A-B wraps
    always_comb begin
        sum         = a_q + b_q;
        diff        = a_q - b_q;
        add_ovf     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        sub_ovf     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
        slt_bit     = diff[WIDTH-1] ^ sub_ovf;
        alu_result  = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (op_q)
            OP_AND: alu_result = a_q & b_q;
            OP_OR:  alu_result = a_q | b_q;
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = add_ovf;
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = sub_ovf;
            end
            OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_NOR: alu_result = ~(a_q | b_q);
            default: alu_illegal = 1'b1;
        endcase
    end

    // Operand capture on the accepting edge; cleared by reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            dest_q <= '0;
        end else if (capture_en) begin
            a_q    <= A;
            b_q    <= B;
            op_q   <= ALU_OP;
            dest_q <= DEST_REG;
        end
    end

    // Execute: result, address and flags update here and then hold until the next execute
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WriteData <= '0;
            WriteReg  <= '0;
            ZERO      <= 1'b0;
            OVERFLOW  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (exec_en) begin
            WriteData <= alu_result;
            WriteReg  <= dest_q;
            ZERO      <= (alu_result == '0);
            OVERFLOW  <= alu_ovf;
            illegal_q <= alu_illegal;
        end
    end

    // Writeback: single-cycle strobes and completion count; r0 is never written
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RegWrite    <= 1'b0;
            ERR_ILLEGAL <= 1'b0;
            OP_COUNT    <= '0;
        end else begin
            RegWrite    <= wb_en && !illegal_q && (dest_q != '0);
            ERR_ILLEGAL <= wb_en && illegal_q;
            if (wb_en) begin
                OP_COUNT <= OP_COUNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_wb.sv
// tb/tb_alu_exec_wb.sv - directed bench for alu_exec_wb with timing/arithmetic reference model
module tb_alu_exec_wb;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  ALU_OP = '0;
    logic [4:0]  DEST_REG = '0;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        ZERO;
    logic        OVERFLOW;
    logic        ERR_ILLEGAL;
    logic [15:0] OP_COUNT;

    alu_exec_wb #(.WIDTH(32), .RADDR_W(5), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .ALU_OP(ALU_OP), .DEST_REG(DEST_REG),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .ZERO(ZERO), .OVERFLOW(OVERFLOW), .ERR_ILLEGAL(ERR_ILLEGAL), .OP_COUNT(OP_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int rw_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the operation definitions, using wide signed integers
    function automatic logic [33:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        longint sa;
        longint sb;
        longint s;
        logic [31:0] r;
        logic ill;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        s   = 0;
        r   = '0;
        ill = 1'b0;
        ovf = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin s = sa + sb; r = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd6:  begin s = sa - sb; r = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r = ~(a | b);
            default: ill = 1'b1;
        endcase
        return {ill, ovf, r};
    endfunction

    // Model state: cycle count since reset, last accept cycle, visible result, completions
    int          cyc = 0;
    int          t_last = 0;
    logic        have_op = 1'b0;
    logic [31:0] p_a = '0;
    logic [31:0] p_b = '0;
    logic [3:0]  p_op = '0;
    logic [4:0]  p_dest = '0;
    logic [31:0] vis_res = '0;
    logic [4:0]  vis_dest = '0;
    logic        vis_ill = 1'b0;
    logic        vis_ovf = 1'b0;
    logic        vis_zero = 1'b0;
    logic [15:0] done = '0;

    // Timing model: accepts spaced at least 3 cycles, result visible 1 cycle and writeback 2 cycles after accept
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cyc      <= 0;
            t_last   <= 0;
            have_op  <= 1'b0;
            vis_res  <= '0;
            vis_dest <= '0;
            vis_ill  <= 1'b0;
            vis_ovf  <= 1'b0;
            vis_zero <= 1'b0;
            done     <= '0;
        end else begin
            cyc <= cyc + 1;
            if (have_op && (cyc + 1 == t_last + 1)) begin
                {vis_ill, vis_ovf, vis_res} <= model_alu(p_a, p_b, p_op);
                vis_zero <= (model_alu(p_a, p_b, p_op) & 34'h0_FFFF_FFFF) == 34'd0;
                vis_dest <= p_dest;
            end
            if (have_op && (cyc + 1 == t_last + 2)) begin
                done <= done + 16'd1;
            end
            if (IN_VALID && (!have_op || (cyc + 1 >= t_last + 3))) begin
                have_op <= 1'b1;
                t_last  <= cyc + 1;
                p_a     <= A;
                p_b     <= B;
                p_op    <= ALU_OP;
                p_dest  <= DEST_REG;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) begin
        int  d;
        logic wb_cyc;
        d = cyc - t_last;
        wb_cyc = have_op && (d == 2);
        chk("in_ready", 32'(IN_READY), 32'(!have_op || (d >= 2)));
        chk("reg_write", 32'(RegWrite), 32'(wb_cyc && !vis_ill && (vis_dest != 5'd0)));
        chk("err_illegal", 32'(ERR_ILLEGAL), 32'(wb_cyc && vis_ill));
        chk("op_count", 32'(OP_COUNT), 32'(done));
        chk("write_data", WriteData, vis_res);
        chk("write_reg", 32'(WriteReg), 32'(vis_dest));
        chk("zero", 32'(ZERO), 32'(vis_zero));
        chk("overflow", 32'(OVERFLOW), 32'(vis_ovf));
        if (RegWrite) rw_seen++;
    end

    // Single op from idle; hand-computed checks in the writeback-visible cycle
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [4:0] dest, input logic [31:0] e_data, input logic e_rw,
                         input logic e_ovf, input logic e_err, input int e_cnt);
        @(negedge CLK); #1;
        IN_VALID = 1'b1; A = a; B = b; ALU_OP = op; DEST_REG = dest;
        @(posedge CLK);
        @(negedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK); #2;
        chk("lit_data", WriteData, e_data);
        chk("lit_rw", 32'(RegWrite), 32'(e_rw));
        chk("lit_wreg", 32'(WriteReg), 32'(dest));
        chk("lit_ovf", 32'(OVERFLOW), 32'(e_ovf));
        chk("lit_err", 32'(ERR_ILLEGAL), 32'(e_err));
        chk("lit_zero", 32'(ZERO), 32'(e_data == 32'd0));
        chk("lit_cnt", 32'(OP_COUNT), 32'(e_cnt));
    endtask

    initial begin
        int rw0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ready", 32'(IN_READY), 32'd1);
        chk("rst_cnt", 32'(OP_COUNT), 32'd0);
        chk("rst_data", WriteData, 32'd0);
        RESET = 1'b0;

        issue(32'd5, 32'd7, 4'b0010, 5'd2, 32'd12, 1'b1, 1'b0, 1'b0, 1);
        issue(32'h8000_0000, 32'd1, 4'b0110, 5'd11, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 2);
        issue(32'h7FFF_FFFF, 32'd1, 4'b0010, 5'd3, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 3);
        issue(32'hFFFF_FFFF, 32'd1, 4'b0111, 5'd4, 32'd1, 1'b1, 1'b0, 1'b0, 4);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 5'd6, 32'd0, 1'b1, 1'b0, 1'b0, 5);
        issue(32'd0, 32'd0, 4'b1100, 5'd8, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 6);
        issue(32'hF0, 32'h3C, 4'b0000, 5'd9, 32'h30, 1'b1, 1'b0, 1'b0, 7);
        issue(32'd9, 32'd4, 4'b0101, 5'd5, 32'd0, 1'b0, 1'b0, 1'b1, 8);
        issue(32'd1, 32'd1, 4'b0010, 5'd0, 32'd2, 1'b0, 1'b0, 1'b0, 9);

        // IN_VALID held high across four back-to-back ops
        rw0 = rw_seen;
        @(negedge CLK); #1;
        IN_VALID = 1'b1; A = 32'd1; B = 32'd2; ALU_OP = 4'b0010; DEST_REG = 5'd1;
        @(posedge CLK);
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK); #1;
            case (i)
                1: begin A = 32'd10; B = 32'd3; ALU_OP = 4'b0110; DEST_REG = 5'd2; end
                2: begin A = 32'h5; B = 32'hA; ALU_OP = 4'b0001; DEST_REG = 5'd3; end
                default: begin A = 32'hFF; B = 32'h0F; ALU_OP = 4'b0000; DEST_REG = 5'd4; end
            endcase
            repeat (3) @(posedge CLK);
        end
        @(negedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); #2;
        chk("b2b_pulses", 32'(rw_seen - rw0), 32'd4);
        chk("b2b_cnt", 32'(OP_COUNT), 32'd13);
        chk("b2b_last", WriteData, 32'h0F);

        // Asynchronous reset while an op is in EXEC
        @(negedge CLK); #1;
        IN_VALID = 1'b1; A = 32'd100; B = 32'd1; ALU_OP = 4'b0010; DEST_REG = 5'd7;
        @(posedge CLK); #2;
        IN_VALID = 1'b0;
        RESET = 1'b1;
        #1;
        chk("mid_rst_cnt", 32'(OP_COUNT), 32'd0);
        chk("mid_rst_rw", 32'(RegWrite), 32'd0);
        chk("mid_rst_ready", 32'(IN_READY), 32'd1);
        chk("mid_rst_data", WriteData, 32'd0);
        repeat (2) @(negedge CLK);
        #1;
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        issue(32'd3, 32'd4, 4'b0010, 5'd9, 32'd7, 1'b1, 1'b0, 1'b0, 1);

        repeat (3) @(posedge CLK);
        @(negedge CLK); #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
